// File: rtl/otter_pc_sequencer_if.sv
// Fetch-side bundle between the PC sequencer,
// program counter, instruction memory and decode.
interface otter_pc_sequencer_if ();
  logic [31:0] PCS_PC_CNT;
  logic        PCS_PC_LD;
  logic [31:0] PCS_PC_DIN;
  logic        PCS_IMEM_REQ;
  logic [31:0] PCS_IMEM_ADDR;
  logic        PCS_IMEM_ACK;
  logic [31:0] PCS_IMEM_DATA;
  logic        PCS_STALL;
  logic        PCS_REDIR_VALID;
  logic [31:0] PCS_REDIR_ADDR;
  logic        PCS_TRAP_VALID;
  logic [31:0] PCS_MTVEC;
  logic        PCS_MRET_VALID;
  logic [31:0] PCS_MEPC;
  logic        PCS_INST_VALID;
  logic [31:0] PCS_INST_DATA;
  logic        PCS_MISALIGN;
  logic [31:0] PCS_FETCH_CNT;

  modport master (
    output PCS_PC_CNT, PCS_IMEM_ACK, PCS_IMEM_DATA,
    output PCS_STALL, PCS_REDIR_VALID, PCS_REDIR_ADDR,
    output PCS_TRAP_VALID, PCS_MTVEC,
    output PCS_MRET_VALID, PCS_MEPC,
    input  PCS_PC_LD, PCS_PC_DIN,
    input  PCS_IMEM_REQ, PCS_IMEM_ADDR,
    input  PCS_INST_VALID, PCS_INST_DATA,
    input  PCS_MISALIGN, PCS_FETCH_CNT
  );

  modport slave (
    input  PCS_PC_CNT, PCS_IMEM_ACK, PCS_IMEM_DATA,
    input  PCS_STALL, PCS_REDIR_VALID, PCS_REDIR_ADDR,
    input  PCS_TRAP_VALID, PCS_MTVEC,
    input  PCS_MRET_VALID, PCS_MEPC,
    output PCS_PC_LD, PCS_PC_DIN,
    output PCS_IMEM_REQ, PCS_IMEM_ADDR,
    output PCS_INST_VALID, PCS_INST_DATA,
    output PCS_MISALIGN, PCS_FETCH_CNT
  );
endinterface

// File: rtl/otter_pc_sequencer.sv
// OTTER PC sequencer: picks the next PC load,
// runs the imem handshake and holds stalled words.
module otter_pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic                 PCS_CLK,
  input  logic                 PCS_RST_N,
  otter_pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        misalign_q, misalign_d;

  logic        pc_ld;
  logic [31:0] pc_din;
  logic        imem_req;
  logic        inst_valid;
  logic [31:0] inst_data;

  logic        ev_any;
  logic        redir_ok;
  logic [31:0] seq_pc;

  assign seq_pc   = bus.PCS_PC_CNT + 32'd4;
  assign redir_ok = (bus.PCS_REDIR_ADDR[1:0] == 2'b00);
  assign ev_any   = bus.PCS_TRAP_VALID
                  | bus.PCS_MRET_VALID
                  | bus.PCS_REDIR_VALID;

  // Next state, PC load decision and delivery
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    fetch_cnt_d = fetch_cnt_q;
    misalign_d  = 1'b0;
    pc_ld       = 1'b0;
    pc_din      = 32'h0;
    imem_req    = 1'b0;
    inst_valid  = 1'b0;
    inst_data   = 32'h0;
    unique case (state_q)
      BOOT: begin
        pc_ld   = 1'b1;
        pc_din  = RESET_VEC;
        state_d = FETCH;
      end
      FETCH, HOLD: begin
        imem_req = (state_q == FETCH);
        if (ev_any) begin
          state_d = FETCH;
          if (bus.PCS_TRAP_VALID) begin
            pc_ld  = 1'b1;
            pc_din = bus.PCS_MTVEC & ~32'h3;
          end else if (bus.PCS_MRET_VALID) begin
            pc_ld  = 1'b1;
            pc_din = bus.PCS_MEPC & ~32'h3;
          end else if (redir_ok) begin
            pc_ld  = 1'b1;
            pc_din = bus.PCS_REDIR_ADDR;
          end else begin
            misalign_d = 1'b1;
          end
        end else if (state_q == HOLD) begin
          inst_valid = 1'b1;
          inst_data  = hold_q;
          if (!bus.PCS_STALL) begin
            pc_ld       = 1'b1;
            pc_din      = seq_pc;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
            state_d     = FETCH;
          end
        end else if (bus.PCS_IMEM_ACK) begin
          inst_valid = 1'b1;
          inst_data  = bus.PCS_IMEM_DATA;
          if (bus.PCS_STALL) begin
            hold_d  = bus.PCS_IMEM_DATA;
            state_d = HOLD;
          end else begin
            pc_ld       = 1'b1;
            pc_din      = seq_pc;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
          end
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    if (!PCS_RST_N) begin
      pc_ld      = 1'b0;
      pc_din     = 32'h0;
      imem_req   = 1'b0;
      inst_valid = 1'b0;
      inst_data  = 32'h0;
    end
  end

  // State, hold word, counter and misalign pulse
  always_ff @(posedge PCS_CLK) begin
    if (!PCS_RST_N) begin
      state_q     <= BOOT;
      hold_q      <= 32'h0;
      fetch_cnt_q <= 32'h0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      fetch_cnt_q <= fetch_cnt_d;
      misalign_q  <= misalign_d;
    end
  end

  assign bus.PCS_PC_LD      = pc_ld;
  assign bus.PCS_PC_DIN     = pc_din;
  assign bus.PCS_IMEM_REQ   = imem_req;
  assign bus.PCS_IMEM_ADDR  = bus.PCS_PC_CNT;
  assign bus.PCS_INST_VALID = inst_valid;
  assign bus.PCS_INST_DATA  = inst_data;
  assign bus.PCS_MISALIGN   = misalign_q;
  assign bus.PCS_FETCH_CNT  = fetch_cnt_q;

endmodule

// File: doc/otter_pc_sequencer.md
# otter_pc_sequencer

Fetch-side controller for the OTTER MCU program counter. Each cycle it decides whether and with what value the program counter is loaded: sequential advance, branch/jump redirect, trap entry or trap return. It also runs the instruction-memory request/acknowledge handshake and holds the fetched instruction while the pipeline stalls. It sits between the program counter, instruction memory and the decode/control unit, and drives the counter's load and data inputs.

## Interface
- RESET_VEC, 32'h0000_0000, PC value loaded in the BOOT state
- PCS_CLK  in  1  system clock; all state updates on the rising edge
- PCS_RST_N  in  1  reset, synchronous, active-low
- PCS_PC_CNT  in  32  current program counter value (counter output)
- PCS_PC_LD  out  1  load strobe to the program counter
- PCS_PC_DIN  out  32  value to load into the program counter
- PCS_IMEM_REQ  out  1  instruction fetch request
- PCS_IMEM_ADDR  out  32  fetch address; always equals PCS_PC_CNT
- PCS_IMEM_ACK  in  1  memory returns data this cycle
- PCS_IMEM_DATA  in  32  instruction word, valid when ACK=1
- PCS_STALL  in  1  downstream cannot accept an instruction
- PCS_REDIR_VALID  in  1  branch/jal/jalr taken
- PCS_REDIR_ADDR  in  32  redirect target
- PCS_TRAP_VALID  in  1  trap entry request
- PCS_MTVEC  in  32  trap vector; bits [1:0] ignored and forced to 0
- PCS_MRET_VALID  in  1  trap return request
- PCS_MEPC  in  32  return address; bits [1:0] forced to 0
- PCS_INST_VALID  out  1  PCS_INST_DATA holds a valid instruction
- PCS_INST_DATA  out  32  delivered instruction word
- PCS_MISALIGN  out  1  one-cycle pulse: redirect target had bits [1:0] ≠ 0
- PCS_FETCH_CNT  out  32  count of instructions accepted downstream; wraps

## Operation
- States: BOOT, FETCH, HOLD.
- Reset (PCS_RST_N=0 at an edge):
  - Next state is BOOT.
  - Held instruction register, PCS_FETCH_CNT and PCS_MISALIGN register clear to 0.
- BOOT:
  - Drives PCS_PC_LD=1 and PCS_PC_DIN=RESET_VEC.
  - All other outputs are 0.
  - Next state is FETCH unconditionally; all event inputs are ignored.
- FETCH:
  - Drives PCS_IMEM_REQ=1.
  - If ACK=0: no load; stay in FETCH with REQ held.
  - If ACK=1: INST_VALID=1 and INST_DATA=IMEM_DATA (combinational pass-through).
  - ACK=1 and STALL=0: PC_LD=1, PC_DIN=PC_CNT+32'd4 (mod 2^32); FETCH_CNT increments.
  - ACK=1 and STALL=1: capture IMEM_DATA into the hold register; go to HOLD.
- HOLD:
  - REQ=0; INST_VALID=1; INST_DATA comes from the hold register.
  - When STALL=0: PC_LD=1, PC_DIN=PC_CNT+4, FETCH_CNT increments, go to FETCH.
- Control events (FETCH or HOLD only). Priority is TRAP > MRET > REDIR > sequential.
  - TRAP: PC_LD=1, PC_DIN={MTVEC[31:2],2'b00}.
  - MRET: PC_LD=1, PC_DIN={MEPC[31:2],2'b00}.
  - REDIR with REDIR_ADDR[1:0]=0: PC_LD=1, PC_DIN=REDIR_ADDR.
  - REDIR with REDIR_ADDR[1:0]≠0: PC_LD=0; MISALIGN pulses 1 in the next cycle; PC is unchanged.
  - Any event overrides STALL.
  - Any event forces INST_VALID=0 in that cycle and squashes a coincident ACK; FETCH_CNT does not increment.
  - After any event, next state is FETCH.
- PC_DIN is 0 in every cycle where PC_LD=0.

## Timing
- PC_LD/PC_DIN are combinational from state and inputs. The counter updates at the next edge, so the new address appears on IMEM_ADDR one cycle after the load.
- Best-case throughput (zero-wait memory, no stall): one instruction per cycle.
- Sequence after reset release: cycle 0 BOOT (load RESET_VEC); cycle 1 FETCH at RESET_VEC.
- Reset asserted mid-fetch or in HOLD: the held instruction is discarded and no load occurs in the reset cycle. The PC is reloaded in BOOT.
- MISALIGN is a registered pulse: high for exactly one cycle after the offending REDIR cycle.
- PC_CNT=32'hFFFF_FFFC with a sequential advance loads 32'h0000_0000 (wrap, no flag).
- FETCH_CNT=32'hFFFF_FFFF followed by an accepted instruction gives 0.

## Test plan
- Reset then free-run:
  - Stimulus: RESET_VEC=0, ACK tied high, STALL=0.
  - Required: PC_DIN sequence 0,4,8,12; FETCH_CNT=3 after three accepted fetches; INST_DATA mirrors IMEM_DATA.
- Wait states then stall:
  - Stimulus: ACK low 2 cycles at PC=0x10, then high with STALL=1 for 3 cycles, IMEM_DATA=0x00500093.
  - Required: REQ held 3 cycles. Then INST_VALID=1 and INST_DATA=0x00500093 held for 3 cycles with REQ=0. On STALL release, PC_LD=1 with PC_DIN=0x14.
- Simultaneous events:
  - Stimulus: TRAP, MRET and REDIR together; MTVEC=0x103, MEPC=0x200, REDIR_ADDR=0x300.
  - Required: PC_DIN=0x100; INST_VALID=0; FETCH_CNT unchanged.
- Misaligned redirect:
  - Stimulus: REDIR_ADDR=0x42 while PC=0x20.
  - Required: PC_LD=0; MISALIGN=1 for exactly one cycle after; PC stays 0x20.
- Redirect during HOLD:
  - Stimulus: REDIR_ADDR=0x80 with STALL=1.
  - Required: PC_LD=1, PC_DIN=0x80; next state FETCH at 0x80; held instruction dropped.
- Reset mid-operation and wrap:
  - Stimulus 1: PCS_RST_N=0 for one cycle while in HOLD.
  - Required 1: outputs 0 that cycle; BOOT loads RESET_VEC next cycle.
  - Stimulus 2: PC=0xFFFF_FFFC with a sequential advance.
  - Required 2: PC_DIN=0.
